// File: rtl/mar_burst.sv
// SAP memory address register with bus decoupling, single-step increment,
// burst sequencer and program-mode address mux in front of the RAM.
module mar_burst #(
    parameter int ADDR_W = 4,
    parameter int BUS_W  = 8,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BUS_W-1:0]  BusIn,
    input  logic              MARIn,
    input  logic              MARInc,
    input  logic              BurstStart,
    input  logic [LEN_W-1:0]  BurstLen,
    input  logic              BurstAbort,
    input  logic              ProgMode,
    input  logic [ADDR_W-1:0] SwAddr,
    output logic [ADDR_W-1:0] RAMIn,
    output logic              Busy,
    output logic              Done,
    output logic              Wrap
);

    localparam logic S_IDLE  = 1'b0;
    localparam logic S_BURST = 1'b1;

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);
    localparam logic [LEN_W-1:0]  LEN_ZERO = '0;

    logic              r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_cnt;
    logic              r_done;
    logic              r_wrap;

    logic              w_busy;
    logic              w_roll;
    logic [ADDR_W-1:0] w_addr_inc;
    logic              w_unused_bus;

    assign w_busy       = (r_state == S_BURST);
    assign w_roll       = &r_addr;
    assign w_addr_inc   = r_addr + ADDR_ONE;
    // Only the low bits address the RAM; the rest of the bus is don't-care.
    assign w_unused_bus = ^BusIn;

    // Address register, burst counter and sequencer state; pulses self-clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_wrap <= 1'b0;
            if (r_state == S_BURST) begin
                if (BurstAbort) begin
                    r_state <= S_IDLE;
                end else if (r_cnt != LEN_ZERO) begin
                    r_addr <= w_addr_inc;
                    r_wrap <= w_roll;
                    r_cnt  <= r_cnt - LEN_ONE;
                end else begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b1;
                end
            end else begin
                if (MARIn) begin
                    r_addr <= BusIn[ADDR_W-1:0];
                end else if (BurstStart) begin
                    if (BurstLen == LEN_ZERO) begin
                        r_done <= 1'b1;
                    end else begin
                        r_state <= S_BURST;
                        r_cnt   <= BurstLen - LEN_ONE;
                    end
                end else if (MARInc) begin
                    r_addr <= w_addr_inc;
                    r_wrap <= w_roll;
                end
            end
        end
    end

    // Manual switches override the register only on the RAM side.
    always_comb begin
        RAMIn = ProgMode ? SwAddr : r_addr;
    end

    assign Busy = w_busy;
    assign Done = r_done;
    assign Wrap = r_wrap;

endmodule

// File: tb/tb_mar_burst.sv
// Self-checking bench for mar_burst: directed steps followed by random
// traffic, all compared against a queue-based address-sequence model.
module tb_mar_burst;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] BusIn = '0;
    logic       MARIn = 1'b0;
    logic       MARInc = 1'b0;
    logic       BurstStart = 1'b0;
    logic [3:0] BurstLen = '0;
    logic       BurstAbort = 1'b0;
    logic       ProgMode = 1'b0;
    logic [3:0] SwAddr = '0;
    logic [3:0] RAMIn;
    logic       Busy;
    logic       Done;
    logic       Wrap;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: current address plus the list of addresses a burst
    // still has to present after the current one.
    int m_addr;
    int m_seq[$];
    bit m_busy;
    bit m_done;
    bit m_wrap;

    mar_burst #(.ADDR_W(4), .BUS_W(8), .LEN_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .BusIn     (BusIn),
        .MARIn     (MARIn),
        .MARInc    (MARInc),
        .BurstStart(BurstStart),
        .BurstLen  (BurstLen),
        .BurstAbort(BurstAbort),
        .ProgMode  (ProgMode),
        .SwAddr    (SwAddr),
        .RAMIn     (RAMIn),
        .Busy      (Busy),
        .Done      (Done),
        .Wrap      (Wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_addr = 0;
        m_seq.delete();
        m_busy = 1'b0;
        m_done = 1'b0;
        m_wrap = 1'b0;
    endtask

    task automatic model_edge();
        int nxt;
        m_done = 1'b0;
        m_wrap = 1'b0;
        if (m_busy) begin
            if (BurstAbort) begin
                m_busy = 1'b0;
                m_seq.delete();
            end else if (m_seq.size() > 0) begin
                nxt = m_seq.pop_front();
                m_wrap = (nxt == 0);
                m_addr = nxt;
            end else begin
                m_busy = 1'b0;
                m_done = 1'b1;
            end
        end else if (MARIn) begin
            m_addr = int'(BusIn) % 16;
        end else if (BurstStart) begin
            if (BurstLen == 0) begin
                m_done = 1'b1;
            end else begin
                m_busy = 1'b1;
                for (int i = 1; i < int'(BurstLen); i++)
                    m_seq.push_back((m_addr + i) % 16);
            end
        end else if (MARInc) begin
            m_wrap = (m_addr == 15);
            m_addr = (m_addr + 1) % 16;
        end
    endtask

    task automatic check_all(input string tag);
        int exp_ram;
        exp_ram = ProgMode ? int'(SwAddr) : m_addr;
        chk({tag, ".RAMIn"}, 32'(RAMIn), 32'(exp_ram));
        chk({tag, ".Busy"},  32'(Busy),  32'(m_busy));
        chk({tag, ".Done"},  32'(Done),  32'(m_done));
        chk({tag, ".Wrap"},  32'(Wrap),  32'(m_wrap));
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic idle_inputs();
        MARIn = 1'b0;
        MARInc = 1'b0;
        BurstStart = 1'b0;
        BurstAbort = 1'b0;
    endtask

    // Called just after a falling edge: pulse reset well clear of both edges.
    task automatic async_reset(input string tag);
        rst = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_all("reset");
        rst = 1'b1;

        // bus load ignores the upper bus bits
        BusIn = 8'hA5;
        MARIn = 1'b1;
        cycle("load_a5");
        chk("load_a5.val", 32'(RAMIn), 32'h5);
        MARIn = 1'b0;
        cycle("load_hold");

        // asynchronous reset takes effect between edges
        async_reset("async_rst");
        chk("async_rst.val", 32'(RAMIn), 32'h0);

        // increment from all-ones rolls over with a single Wrap pulse
        BusIn = 8'h0F;
        MARIn = 1'b1;
        cycle("load_f");
        MARIn = 1'b0;
        MARInc = 1'b1;
        cycle("inc_wrap");
        chk("inc_wrap.flag", 32'(Wrap), 32'h1);
        MARInc = 1'b0;
        cycle("inc_after");

        // burst of 3 from E wraps through 0; mid-burst load is ignored
        BusIn = 8'h0E;
        MARIn = 1'b1;
        cycle("load_e");
        MARIn = 1'b0;
        BurstLen = 4'd3;
        BurstStart = 1'b1;
        cycle("b3_c1");
        chk("b3_c1.busy", 32'(Busy), 32'h1);
        BurstStart = 1'b0;
        cycle("b3_c2");
        BusIn = 8'h77;
        MARIn = 1'b1;
        cycle("b3_c3");
        chk("b3_c3.addr", 32'(RAMIn), 32'h0);
        MARIn = 1'b0;
        cycle("b3_done");
        chk("b3_done.flag", 32'(Done), 32'h1);
        cycle("b3_after");

        // zero-length burst only pulses Done
        BurstLen = 4'd0;
        BurstStart = 1'b1;
        cycle("b0");
        BurstStart = 1'b0;
        cycle("b0_after");

        // abort in the second cycle of a length-5 burst
        BurstLen = 4'd5;
        BurstStart = 1'b1;
        cycle("ab_c1");
        BurstStart = 1'b0;
        cycle("ab_c2");
        BurstAbort = 1'b1;
        cycle("ab_stop");
        BurstAbort = 1'b0;
        cycle("ab_after");

        // program mode shows switches but the register still loads
        ProgMode = 1'b1;
        SwAddr = 4'h9;
        #1;
        check_all("pm_on");
        BusIn = 8'h03;
        MARIn = 1'b1;
        cycle("pm_load");
        MARIn = 1'b0;
        cycle("pm_hold");
        ProgMode = 1'b0;
        #1;
        check_all("pm_off");
        chk("pm_off.val", 32'(RAMIn), 32'h3);

        // maximum-length burst crossing the address space
        BurstLen = 4'd15;
        BurstStart = 1'b1;
        cycle("bmax_c1");
        BurstStart = 1'b0;
        for (int i = 0; i < 16; i++) cycle("bmax");

        // random traffic
        for (int i = 0; i < 600; i++) begin
            BusIn      = 8'($urandom);
            MARIn      = ($urandom_range(0, 5) == 0);
            MARInc     = ($urandom_range(0, 2) == 0);
            BurstStart = ($urandom_range(0, 6) == 0);
            BurstLen   = 4'($urandom);
            BurstAbort = ($urandom_range(0, 12) == 0);
            ProgMode   = ($urandom_range(0, 4) == 0);
            SwAddr     = 4'($urandom);
            cycle("rnd");
            if ($urandom_range(0, 80) == 0) async_reset("rnd_rst");
        end
        idle_inputs();
        ProgMode = 1'b0;
        cycle("final");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
